// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls, synchronous imem port and decode outputs.
// With FETCH_PERF_CNT_EN defined it also carries the fetch_count / bubble_count outputs.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 20
);
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [ADDR_W-1:0]  pc_fetch;
  logic [INSTR_W-1:0] instr_decode;
  logic [ADDR_W-1:0]  pc_decode;
  logic               valid_decode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        fetch_count;
  logic [31:0]        bubble_count;

  modport master (
    input  stall, flush, branch_taken, branch_target, imem_data,
    output imem_addr, pc_fetch, instr_decode, pc_decode, valid_decode,
    output fetch_count, bubble_count
  );
  modport slave (
    output stall, flush, branch_taken, branch_target, imem_data,
    input  imem_addr, pc_fetch, instr_decode, pc_decode, valid_decode,
    input  fetch_count, bubble_count
  );
`else
  modport master (
    input  stall, flush, branch_taken, branch_target, imem_data,
    output imem_addr, pc_fetch, instr_decode, pc_decode, valid_decode
  );
  modport slave (
    output stall, flush, branch_taken, branch_target, imem_data,
    input  imem_addr, pc_fetch, instr_decode, pc_decode, valid_decode
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, redirect mux, in-flight imem request tracker and fetch->decode register.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / bubble_count performance counters.
module fetch_unit #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 20,
  parameter int unsigned        PC_STEP   = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

  logic [ADDR_W-1:0]  pc_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [ADDR_W-1:0]  req_pc_p1;
  logic               vld_p1;
  logic [INSTR_W-1:0] instr_p2;
  logic [ADDR_W-1:0]  pc_p2;
  logic               vld_p2;
  logic               hold;

  // A stall without flush freezes the pipe; flush always advances it with a bubble.
  assign hold = bus.stall && !bus.flush;

  always_comb begin
    addr_p0 = pc_p0;
    if (!reset)
      addr_p0 = RESET_PC;
    else if (hold)
      addr_p0 = req_pc_p1;
    else if (bus.branch_taken)
      addr_p0 = bus.branch_target;
  end

  // p0 -> p1: issue the request and advance the sequential PC
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_p0     <= RESET_PC;
      req_pc_p1 <= '0;
      vld_p1    <= 1'b0;
    end else if (hold) begin
      if (bus.branch_taken)
        pc_p0 <= bus.branch_target;
    end else begin
      pc_p0     <= pc_inc(addr_p0);
      req_pc_p1 <= addr_p0;
      vld_p1    <= 1'b1;
    end
  end

  // p1 -> p2: capture returning memory data into the decode register
  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      instr_p2 <= NOP_INSTR;
      pc_p2    <= '0;
      vld_p2   <= 1'b0;
    end else if (!bus.stall) begin
      instr_p2 <= bus.imem_data;
      pc_p2    <= req_pc_p1;
      vld_p2   <= vld_p1;
    end
  end

  assign bus.imem_addr    = addr_p0;
  assign bus.pc_fetch     = pc_p0;
  assign bus.instr_decode = instr_p2;
  assign bus.pc_decode    = pc_p2;
  assign bus.valid_decode = vld_p2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.flush)
        bubble_cnt <= bubble_cnt + 32'd1;
      else if (!bus.stall && vld_p1)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign bus.fetch_count  = fetch_cnt;
  assign bus.bubble_count = bubble_cnt;
`endif

endmodule
